param_counter: RTL and testbench
================================

// Module: param_counter
// PURPOSE
//  Parametrised successor of the team's 4-bit up counter. Adds configurable width,
//  modulus, up/down direction, parallel load, wrap/saturate mode, a clock-enable
//  prescaler and a terminal-count pulse. Serves as the shared timer/event-count
//  primitive for control blocks; all outputs are registered.
// PARAMETERS
//  WIDTH     4         count width in bits (1..32)
//  MAX_VAL   2**WIDTH-1  terminal value; count range is 0..MAX_VAL (MAX_VAL < 2**WIDTH)
//  PRESCALE  1         enabled cycles per count step (1 = every enabled cycle; 1..65535)
// PORTS
//  clk        in   1      single clock, rising edge
//  reset      in   1      synchronous, active-high
//  enable     in   1      count enable; also gates the prescaler
//  dir        in   1      1 = up, 0 = down
//  sat_mode   in   1      1 = saturate at the bounds, 0 = wrap modulo MAX_VAL+1
//  load       in   1      parallel load strobe
//  load_val   in   WIDTH  value for load
//  count      out  WIDTH  current count
//  tc         out  1      terminal-count pulse, one cycle
//  at_bound   out  1      level: count==MAX_VAL when dir=1, count==0 when dir=0
// BEHAVIOUR
//  - Reset (sync, highest priority): count=0, tc=0, prescaler=0; at_bound follows
//    count/dir (0 and dir=0 -> 1). Reset asserted mid-operation wins over load/enable.
//  - Priority per edge: reset > load > enable step.
//  - load: count <= min(load_val, MAX_VAL) next cycle; prescaler cleared; tc=0.
//  - Prescaler: increments on enabled cycles; at PRESCALE-1 it wraps to 0 and a step
//    occurs on that edge. enable=0 holds prescaler and count. PRESCALE=1 -> step on
//    every enabled cycle (latency 1 clk from enable to count change).
//  - Step, dir=1: count<MAX_VAL -> count+1; count==MAX_VAL -> wrap: 0, sat: hold.
//  - Step, dir=0: count>0 -> count-1; count==0 -> wrap: MAX_VAL, sat: hold.
//  - tc is 1 for exactly the cycle after a step taken at a bound (wrap or saturate
//    attempt); 0 otherwise. In sat_mode tc re-pulses on each further held step.
//  - dir/sat_mode changes take effect on the next step; no pipeline flush needed.
//  - Arithmetic done at WIDTH+1 bits internally; no overflow beyond MAX_VAL ever visible.
//  - MAX_VAL not a power of two: wrap is explicit compare, not natural rollover.
// CONFIGURATION
//  PARAM_COUNTER_CAPTURE_EN defined: adds ports capture (in,1) and cap_val (out,WIDTH)
//   and cap_valid (out,1). capture=1 latches count (pre-update value of that edge) into
//   cap_val and sets cap_valid=1 next cycle; reset clears both; load does not.
//  Not defined: ports absent, no capture logic synthesised.
// STRUCTURE
//  - Package counter_pkg: PRESCALE_W (localparam width of prescaler), DIR_UP/DIR_DOWN
//    and MODE_WRAP/MODE_SAT encoding constants, clamp function for load_val.
//  - One sub-module: count_prescaler (PRESCALE param; enable, clear -> step pulse),
//    bypassed by generate when PRESCALE==1.
//  - Parameter checks in elaboration: MAX_VAL<2**WIDTH, PRESCALE>=1.
// TESTING (WIDTH=4 unless noted)
//  1 reset=1 2 clks, then enable=1 dir=1 PRESCALE=1 -> count 0,1,..,15,0; tc=1 on cycle
//    after the 15->0 step only.
//  2 MAX_VAL=9, dir=0 from reset -> count 0,9,8,..; sat_mode=1 at 0 -> count holds 0,
//    tc pulses every enabled cycle, at_bound=1.
//  3 load=1 load_val=12 with MAX_VAL=9 -> count=9 next cycle; load and enable same
//    cycle -> load wins, no step.
//  4 PRESCALE=3, enable=1 -> count advances every 3rd cycle; enable drop for 2 cycles
//    mid-period -> step delayed exactly 2 cycles.
//  5 count=7 counting, assert reset one cycle with load=1 -> count=0, tc=0, prescaler 0.
//  6 PARAM_COUNTER_CAPTURE_EN: capture at count=5 while stepping -> cap_val=5,
//    cap_valid=1 next cycle; reset -> cap_valid=0.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared constants and helpers for param_counter: prescaler width, direction/mode
// encodings and the load-value clamp.
package counter_pkg;

  localparam int PRESCALE_W = 16;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  function automatic logic [32:0] clamp(input logic [32:0] v, input logic [32:0] max_v);
    return (v > max_v) ? max_v : v;
  endfunction

endpackage

// File: rtl/count_prescaler.sv
// Enable-gated prescaler: emits a one-cycle step on every PRESCALE-th enabled cycle.
// clear restarts the period; reset is synchronous active-high.
module count_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic step
);

  localparam logic [PRESCALE_W-1:0] LAST = PRESCALE_W'(PRESCALE - 1);

  logic [PRESCALE_W-1:0] pre_q, pre_d;

  assign step = enable && (pre_q == LAST);

  always_comb begin
    pre_d = pre_q;
    if (clear)       pre_d = '0;
    else if (enable) pre_d = (pre_q == LAST) ? '0 : pre_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) pre_q <= '0;
    else       pre_q <= pre_d;
  end

endmodule

// File: rtl/param_counter.sv
// Parametrised up/down counter with load, wrap/saturate, prescaler and tc pulse.
// Optional capture port set enabled by defining PARAM_COUNTER_CAPTURE_EN.
module param_counter
  import counter_pkg::*;
#(
  parameter int              WIDTH    = 4,
  parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 1,
  parameter int              PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             dir,
  input  logic             sat_mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             at_bound
`ifdef PARAM_COUNTER_CAPTURE_EN
  ,
  input  logic             capture,
  output logic [WIDTH-1:0] cap_val,
  output logic             cap_valid
`endif
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_chk_width
    $error("param_counter: WIDTH must be 1..32");
  end
  if (MAX_VAL >= (64'd1 << WIDTH)) begin : g_chk_max
    $error("param_counter: MAX_VAL must be below 2**WIDTH");
  end
  if (PRESCALE < 1 || PRESCALE > 65535) begin : g_chk_pre
    $error("param_counter: PRESCALE must be 1..65535");
  end

  localparam logic [WIDTH:0] MAX_E = MAX_VAL[WIDTH:0];

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic [WIDTH:0]   count_ext;
  logic             step;

  if (PRESCALE == 1) begin : g_no_pre
    assign step = enable;
  end else begin : g_pre
    count_prescaler #(.PRESCALE(PRESCALE)) u_pre (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .clear  (load),
      .step   (step)
    );
  end

  // Extended by one bit so +1 at MAX_VAL can never alias back into range.
  assign count_ext = {1'b0, count_q};

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    if (load) begin
      count_d = WIDTH'(clamp(33'(load_val), 33'(MAX_E)));
    end else if (step) begin
      if (dir == DIR_UP) begin
        if (count_ext == MAX_E) begin
          tc_d = 1'b1;
          if (sat_mode == MODE_WRAP) count_d = '0;
        end else begin
          count_d = WIDTH'(count_ext + 1'b1);
        end
      end else begin
        if (count_ext == '0) begin
          tc_d = 1'b1;
          if (sat_mode == MODE_WRAP) count_d = WIDTH'(MAX_E);
        end else begin
          count_d = WIDTH'(count_ext - 1'b1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  assign count    = count_q;
  assign tc       = tc_q;
  assign at_bound = (dir == DIR_UP) ? (count_ext == MAX_E) : (count_q == '0);

`ifdef PARAM_COUNTER_CAPTURE_EN
  logic [WIDTH-1:0] cap_val_q, cap_val_d;
  logic             cap_valid_q, cap_valid_d;

  // Captures the pre-update count; load leaves the captured value alone.
  always_comb begin
    cap_val_d   = capture ? count_q : cap_val_q;
    cap_valid_d = cap_valid_q | capture;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cap_val_q   <= '0;
      cap_valid_q <= 1'b0;
    end else begin
      cap_val_q   <= cap_val_d;
      cap_valid_q <= cap_valid_d;
    end
  end

  assign cap_val   = cap_val_q;
  assign cap_valid = cap_valid_q;
`endif

endmodule

// File: tb/tb_param_counter.sv
// Randomised scoreboard bench for param_counter: two instances (full-range/PRESCALE=1
// and MAX_VAL=9/PRESCALE=3) share stimulus; a monitor checks each against its model.
module tb_param_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0, dir = 1'b1, sat_mode = 1'b0, load = 1'b0, capture = 1'b0;
  logic [3:0] load_val = '0;
  logic [3:0] count_a, count_b;
  logic       tc_a, tc_b, ab_a, ab_b;
  logic [3:0] cap_val_a, cap_val_b;
  logic       cap_valid_a, cap_valid_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  param_counter #(.WIDTH(4), .PRESCALE(1)) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .dir(dir), .sat_mode(sat_mode),
    .load(load), .load_val(load_val), .count(count_a), .tc(tc_a), .at_bound(ab_a)
`ifdef PARAM_COUNTER_CAPTURE_EN
    , .capture(capture), .cap_val(cap_val_a), .cap_valid(cap_valid_a)
`endif
  );

  param_counter #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(3)) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .dir(dir), .sat_mode(sat_mode),
    .load(load), .load_val(load_val), .count(count_b), .tc(tc_b), .at_bound(ab_b)
`ifdef PARAM_COUNTER_CAPTURE_EN
    , .capture(capture), .cap_val(cap_val_b), .cap_valid(cap_valid_b)
`endif
  );

`ifndef PARAM_COUNTER_CAPTURE_EN
  assign cap_val_a = '0; assign cap_valid_a = 1'b0;
  assign cap_val_b = '0; assign cap_valid_b = 1'b0;
`endif

  typedef struct {
    int cnt;
    int pre;
    bit tc;
    int cap;
    bit capv;
  } mst_t;

  typedef struct {
    int cnt;
    bit tc;
    bit ab;
    int cap;
    bit capv;
  } exp_t;

  mst_t ma, mb;
  exp_t qa[$], qb[$];

  // Behavioural model: 'pre' counts enabled cycles since the last step.
  function automatic mst_t mstep(mst_t s, int maxv, int ps, bit rst, bit ld, int lv,
                                 bit en, bit dr, bit sat, bit cap);
    mst_t n = s;
    n.tc = 0;
    if (rst) begin
      n.cnt = 0; n.pre = 0; n.cap = 0; n.capv = 0;
      return n;
    end
    if (cap) begin n.cap = s.cnt; n.capv = 1; end
    if (ld) begin
      n.cnt = (lv > maxv) ? maxv : lv;
      n.pre = 0;
    end else if (en) begin
      n.pre = s.pre + 1;
      if (n.pre == ps) begin
        n.pre = 0;
        if (dr) begin
          if (s.cnt == maxv) begin n.tc = 1; n.cnt = sat ? s.cnt : 0; end
          else n.cnt = s.cnt + 1;
        end else begin
          if (s.cnt == 0) begin n.tc = 1; n.cnt = sat ? 0 : maxv; end
          else n.cnt = s.cnt - 1;
        end
      end
    end
    return n;
  endfunction

  function automatic exp_t to_exp(mst_t s, int maxv, bit dr);
    exp_t e;
    e.cnt = s.cnt; e.tc = s.tc; e.cap = s.cap; e.capv = s.capv;
    e.ab = dr ? (s.cnt == maxv) : (s.cnt == 0);
    return e;
  endfunction

  task automatic drive(bit rst, bit ld, int lv, bit en, bit dr, bit sat, bit cap);
    @(negedge clk);
    reset = rst; load = ld; load_val = 4'(lv); enable = en; dir = dr;
    sat_mode = sat; capture = cap;
    ma = mstep(ma, 15, 1, rst, ld, lv, en, dr, sat, cap);
    mb = mstep(mb, 9, 3, rst, ld, lv, en, dr, sat, cap);
    qa.push_back(to_exp(ma, 15, dr));
    qb.push_back(to_exp(mb, 9, dr));
  endtask

  task automatic cmp(string name, int act, int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s t=%0t got %0d expected %0d", name, $time, act, exp_v);
    end
  endtask

  // Monitor: outputs are valid every cycle; pop one expectation per edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (qa.size() > 0) begin
        e = qa.pop_front();
        cmp("a.count", int'(count_a), e.cnt);
        cmp("a.tc", int'(tc_a), int'(e.tc));
        cmp("a.at_bound", int'(ab_a), int'(e.ab));
`ifdef PARAM_COUNTER_CAPTURE_EN
        cmp("a.cap_valid", int'(cap_valid_a), int'(e.capv));
        if (e.capv) cmp("a.cap_val", int'(cap_val_a), e.cap);
`endif
      end
      if (qb.size() > 0) begin
        e = qb.pop_front();
        cmp("b.count", int'(count_b), e.cnt);
        cmp("b.tc", int'(tc_b), int'(e.tc));
        cmp("b.at_bound", int'(ab_b), int'(e.ab));
`ifdef PARAM_COUNTER_CAPTURE_EN
        cmp("b.cap_valid", int'(cap_valid_b), int'(e.capv));
        if (e.capv) cmp("b.cap_val", int'(cap_val_b), e.cap);
`endif
      end
    end
  end

  initial begin
    bit r_dir, r_sat;
    ma = '{default: 0};
    mb = '{default: 0};
    repeat (2) drive(1, 0, 0, 0, 1, 0, 0);
    // Count up through the full range and wrap.
    repeat (20) drive(0, 0, 0, 1, 1, 0, 0);
    // Down from reset into saturation at 0.
    drive(1, 0, 0, 0, 0, 0, 0);
    repeat (6) drive(0, 0, 0, 1, 0, 0, 0);
    repeat (30) drive(0, 0, 0, 1, 0, 1, 0);
    // Over-range load, and load together with enable.
    drive(0, 1, 12, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0);
    drive(0, 1, 3, 1, 1, 0, 0);
    repeat (4) drive(0, 0, 0, 1, 1, 0, 0);
    // Enable gap mid-period, then capture, then reset colliding with load.
    drive(0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 1);
    repeat (5) drive(0, 0, 0, 1, 1, 0, 0);
    drive(1, 1, 7, 1, 1, 0, 1);
    repeat (3) drive(0, 0, 0, 1, 1, 0, 0);
    r_dir = 1; r_sat = 0;
    repeat (600) begin
      if ($urandom_range(0, 19) == 0) r_dir = ~r_dir;
      if ($urandom_range(0, 24) == 0) r_sat = ~r_sat;
      drive($urandom_range(0, 59) == 0, $urandom_range(0, 11) == 0,
            int'($urandom_range(0, 15)), $urandom_range(0, 3) != 0, r_dir, r_sat,
            $urandom_range(0, 9) == 0);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d/%0d pending expected 0", qa.size(), qb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
